// File: rtl/mem_pkg.sv
// Shared types and constants for the 8-row memory array sequencing controller.
package mem_pkg;

    localparam int ADDR_W_DEF = 3;
    localparam int DATA_W_DEF = 4;
    localparam int PHASE_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        PRECH,
        ACT,
        SENSE,
        WRITE,
        RESP
    } mem_state_t;

endpackage

// File: rtl/mem_phase_timer.sv
// Loadable down-counter that times the multi-cycle precharge and sense phases.
module mem_phase_timer
    import mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic [PHASE_W-1:0] i_load_val,
    output logic               o_done
);

    logic [PHASE_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_done = (r_count == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Sequencing controller for the 8-row memory array: accepts single-word requests
// and steps the array through precharge, wordline, write-drive and sense phases.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int PRE_CYCLES   = 1,
    parameter int SENSE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] row_addr,
    output logic              wl_en,
    output logic              precharge,
    output logic              wr_en,
    output logic [DATA_W-1:0] bl_wdata,
    output logic              sense_en,
    input  logic [DATA_W-1:0] bl_rdata
);

    localparam logic [PHASE_W-1:0] PRE_LOAD   = PHASE_W'(PRE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] SENSE_LOAD = PHASE_W'(SENSE_CYCLES - 1);

    mem_state_t         r_state;
    logic               r_we;
    logic [DATA_W-1:0]  r_wdata;
    logic [ADDR_W-1:0]  r_row_addr;
    logic               r_wl_en;
    logic               r_precharge;
    logic               r_wr_en;
    logic               r_sense_en;
    logic               r_rsp_valid;
    logic [DATA_W-1:0]  r_bl_wdata;
    logic [DATA_W-1:0]  r_rsp_rdata;

    logic               w_accept;
    logic               w_done;
    logic               w_load;
    logic [PHASE_W-1:0] w_load_val;

    // Ready drops while reset is held so no request is accepted on a reset edge.
    assign req_ready = (r_state == IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            IDLE: begin
                w_load     = w_accept;
                w_load_val = PRE_LOAD;
            end
            PRECH: w_load = w_done;
            ACT: begin
                w_load     = 1'b1;
                w_load_val = r_we ? '0 : SENSE_LOAD;
            end
            SENSE:   w_load = w_done;
            default: w_load = 1'b1;
        endcase
    end

    mem_phase_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_row_addr  <= '0;
            r_wl_en     <= 1'b0;
            r_precharge <= 1'b0;
            r_wr_en     <= 1'b0;
            r_sense_en  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_bl_wdata  <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_wr_en     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_bl_wdata  <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_we        <= req_we;
                        r_wdata     <= req_wdata;
                        r_row_addr  <= req_addr;
                        r_precharge <= 1'b1;
                        r_state     <= PRECH;
                    end
                end
                PRECH: begin
                    if (w_done) begin
                        r_precharge <= 1'b0;
                        r_wl_en     <= 1'b1;
                        r_state     <= ACT;
                    end
                end
                ACT: begin
                    if (r_we) begin
                        r_wr_en    <= 1'b1;
                        r_bl_wdata <= r_wdata;
                        r_state    <= WRITE;
                    end else begin
                        r_sense_en <= 1'b1;
                        r_state    <= SENSE;
                    end
                end
                // Sense amp outputs are captured on the final sense cycle only.
                SENSE: begin
                    if (w_done) begin
                        r_wl_en     <= 1'b0;
                        r_sense_en  <= 1'b0;
                        r_rsp_rdata <= bl_rdata;
                        r_rsp_valid <= 1'b1;
                        r_state     <= RESP;
                    end
                end
                WRITE: begin
                    r_wl_en <= 1'b0;
                    r_state <= IDLE;
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign row_addr  = r_row_addr;
    assign wl_en     = r_wl_en;
    assign precharge = r_precharge;
    assign wr_en     = r_wr_en;
    assign bl_wdata  = r_bl_wdata;
    assign sense_en  = r_sense_en;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: a default-timing instance and a PRE=3/SENSE=1
// instance, each driven with random requests and checked against a phase-level model.
module tb_mem_ctrl;

    localparam int NDUT = 2;
    localparam int AW   = 3;
    localparam int DW   = 4;

    typedef struct {
        int              dut;
        int              due;
        logic [DW-1:0]   data;
    } rspExp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          reqValid [NDUT];
    logic          reqReady [NDUT];
    logic          reqWe    [NDUT];
    logic [AW-1:0] reqAddr  [NDUT];
    logic [DW-1:0] reqWdata [NDUT];
    logic          rspValid [NDUT];
    logic [DW-1:0] rspRdata [NDUT];
    logic [AW-1:0] rowAddr  [NDUT];
    logic          wlEn     [NDUT];
    logic          prechg   [NDUT];
    logic          wrEn     [NDUT];
    logic [DW-1:0] blWdata  [NDUT];
    logic          senseEn  [NDUT];
    logic [DW-1:0] blRdata  [NDUT];
    logic [DW-1:0] arrayMem [NDUT][8];

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  stimTimeouts = 0;
    bit  armed = 1'b0;
    bit  finishReq = 1'b0;
    bit  monitorDone = 1'b0;

    // Reference model state, advanced once per cycle by the monitor.
    bit            busy      [NDUT];
    int            opStart   [NDUT];
    bit            opWe      [NDUT];
    logic [AW-1:0] opAddr    [NDUT];
    logic [DW-1:0] opData    [NDUT];
    logic [AW-1:0] expRow    [NDUT];
    logic [DW-1:0] expRdata  [NDUT];
    logic [DW-1:0] refMem    [NDUT][8];
    bit            prevRsp   [NDUT];
    rspExp_t       rspQ[$];

    always #5 clk = ~clk;

    function automatic int preOf(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int senseOf(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    for (genvar g = 0; g < NDUT; g++) begin : gDut
        mem_ctrl #(
            .ADDR_W       (AW),
            .DATA_W       (DW),
            .PRE_CYCLES   ((g == 0) ? 1 : 3),
            .SENSE_CYCLES ((g == 0) ? 2 : 1)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (reqValid[g]),
            .req_ready (reqReady[g]),
            .req_we    (reqWe[g]),
            .req_addr  (reqAddr[g]),
            .req_wdata (reqWdata[g]),
            .rsp_valid (rspValid[g]),
            .rsp_rdata (rspRdata[g]),
            .row_addr  (rowAddr[g]),
            .wl_en     (wlEn[g]),
            .precharge (prechg[g]),
            .wr_en     (wrEn[g]),
            .bl_wdata  (blWdata[g]),
            .sense_en  (senseEn[g]),
            .bl_rdata  (blRdata[g])
        );
        assign blRdata[g] = arrayMem[g][rowAddr[g]];
    end

    // Behavioural storage array: write drivers update the selected row.
    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (wrEn[d]) arrayMem[d][rowAddr[d]] <= blWdata[d];
        end
    end

    task automatic checkOutput(input int d);
        int            k;
        int            pre;
        int            sen;
        bit            ePre;
        bit            eWl;
        bit            eSe;
        bit            eWr;
        logic [DW-1:0] eBlw;
        logic [DW-1:0] eRd;
        logic [14:0]   act;
        logic [14:0]   exp;
        bit            eReady;
        int            idx;
        k    = cyc - opStart[d];
        pre  = preOf(d);
        sen  = senseOf(d);
        ePre = 1'b0;
        eWl  = 1'b0;
        eSe  = 1'b0;
        eWr  = 1'b0;
        eBlw = '0;
        eRd  = expRdata[d];
        if (busy[d]) begin
            ePre = (k >= 1) && (k <= pre);
            eSe  = !opWe[d] && (k >= pre + 2) && (k <= pre + 1 + sen);
            eWr  = opWe[d] && (k == pre + 2);
            eWl  = (k == pre + 1) || eSe || eWr;
            if (eWr) eBlw = opData[d];
            if (!opWe[d] && k == pre + sen + 2) eRd = opData[d];
        end
        act = {prechg[d], wlEn[d], senseEn[d], wrEn[d], blWdata[d], rowAddr[d], rspRdata[d]};
        exp = {ePre, eWl, eSe, eWr, eBlw, expRow[d], eRd};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL ctrl dut%0d cycle %0d: {pre,wl,se,wr,blw,row,rd} got %h want %h",
                     d, cyc, act, exp);
        end

        eReady = !rst && !busy[d];
        checks++;
        if (reqReady[d] !== eReady) begin
            failures++;
            $display("[TB] FAIL req_ready dut%0d cycle %0d: got %b want %b", d, cyc, reqReady[d], eReady);
        end

        checks++;
        if ((wlEn[d] && prechg[d]) || (wrEn[d] && senseEn[d]) || (rspValid[d] && prevRsp[d])) begin
            failures++;
            $display("[TB] FAIL invariant dut%0d cycle %0d: wl=%b pre=%b wr=%b se=%b rsp=%b prevRsp=%b",
                     d, cyc, wlEn[d], prechg[d], wrEn[d], senseEn[d], rspValid[d], prevRsp[d]);
        end
        prevRsp[d] = rspValid[d];

        idx = -1;
        for (int i = 0; i < rspQ.size(); i++) begin
            if (rspQ[i].dut == d) begin
                idx = i;
                break;
            end
        end
        if (rspValid[d]) begin
            checks++;
            if (idx < 0) begin
                failures++;
                $display("[TB] FAIL rsp_unexpected dut%0d cycle %0d: got rsp_valid=1 want none pending", d, cyc);
            end else begin
                if (rspQ[idx].due != cyc || rspRdata[d] !== rspQ[idx].data) begin
                    failures++;
                    $display("[TB] FAIL rsp dut%0d: got cycle %0d data %h want cycle %0d data %h",
                             d, cyc, rspRdata[d], rspQ[idx].due, rspQ[idx].data);
                end
                rspQ.delete(idx);
            end
        end else if (idx >= 0 && rspQ[idx].due <= cyc) begin
            checks++;
            failures++;
            $display("[TB] FAIL rsp_missing dut%0d cycle %0d: got no rsp_valid want data %h at cycle %0d",
                     d, cyc, rspQ[idx].data, rspQ[idx].due);
            rspQ.delete(idx);
        end
    endtask

    task automatic updateModel(input int d);
        int  k;
        int  pre;
        int  sen;
        bit  readyNow;
        k        = cyc - opStart[d];
        pre      = preOf(d);
        sen      = senseOf(d);
        readyNow = !rst && !busy[d];
        if (busy[d]) begin
            if (opWe[d] && k == pre + 2) begin
                refMem[d][opAddr[d]] = opData[d];
                busy[d] = 1'b0;
            end else if (!opWe[d] && k == pre + sen + 2) begin
                expRdata[d] = opData[d];
                busy[d] = 1'b0;
            end
        end
        if (rst) begin
            busy[d]     = 1'b0;
            expRow[d]   = '0;
            expRdata[d] = '0;
            for (int i = rspQ.size() - 1; i >= 0; i--) begin
                if (rspQ[i].dut == d) rspQ.delete(i);
            end
        end else if (readyNow && reqValid[d]) begin
            busy[d]    = 1'b1;
            opStart[d] = cyc;
            opWe[d]    = reqWe[d];
            opAddr[d]  = reqAddr[d];
            opData[d]  = reqWe[d] ? reqWdata[d] : refMem[d][reqAddr[d]];
            expRow[d]  = reqAddr[d];
            if (!reqWe[d]) rspQ.push_back('{dut: d, due: cyc + pre + sen + 2, data: opData[d]});
        end
    endtask

    // Monitor: compares every cycle away from the active edge, then advances the model.
    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < NDUT; d++) begin
            if (armed) checkOutput(d);
            updateModel(d);
        end
        if (rst) armed = 1'b1;
        if (finishReq && !monitorDone) begin
            checks++;
            if (rspQ.size() != 0 || stimTimeouts != 0) begin
                failures++;
                $display("[TB] FAIL drain: got %0d pending responses, %0d stalled requests want 0, 0",
                         rspQ.size(), stimTimeouts);
            end
            monitorDone = 1'b1;
        end
    end

    task automatic applyStimulus(input int d, input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] data);
        bit accepted;
        accepted    = 1'b0;
        reqValid[d] = 1'b1;
        reqWe[d]    = we;
        reqAddr[d]  = addr;
        reqWdata[d] = data;
        for (int n = 0; n < 60 && !accepted; n++) begin
            @(negedge clk);
            if (reqReady[d]) accepted = 1'b1;
        end
        @(posedge clk);
        #1;
        reqValid[d] = 1'b0;
        if (!accepted) stimTimeouts++;
    endtask

    task automatic idleGap();
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        for (int d = 0; d < NDUT; d++) begin
            reqValid[d] = 1'b0;
            reqWe[d]    = 1'b0;
            reqAddr[d]  = '0;
            reqWdata[d] = '0;
            busy[d]     = 1'b0;
            opStart[d]  = 0;
            expRow[d]   = '0;
            expRdata[d] = '0;
            prevRsp[d]  = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        applyStimulus(0, 1'b1, 3'd5, 4'hA);
        applyStimulus(0, 1'b0, 3'd5, 4'h0);

        for (int a = 0; a < 8; a++) applyStimulus(0, 1'b1, 3'(a), 4'(a) ^ 4'hF);
        for (int a = 0; a < 8; a++) applyStimulus(0, 1'b0, 3'(a), 4'h0);

        // Abort a read while it is sensing; reset is held for three edges.
        applyStimulus(0, 1'b0, 3'd3, 4'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        repeat (40) begin
            idleGap();
            applyStimulus(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom));
        end

        applyStimulus(1, 1'b1, 3'd2, 4'h6);
        applyStimulus(1, 1'b0, 3'd2, 4'h0);
        for (int a = 0; a < 8; a++) applyStimulus(1, 1'b1, 3'(a), 4'($urandom));
        repeat (20) begin
            idleGap();
            applyStimulus(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 4'($urandom));
        end

        repeat (12) @(posedge clk);
        finishReq = 1'b1;
        for (int i = 0; i < 10 && !monitorDone; i++) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
